// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the ccff chain loader.
// Contents:
//   ccff_state_e  - loader FSM states
//   nwords()      - number of bitstream words needed to fill a chain
//   rem_width()   - width of the "bits left on the chain" counter
//   cnt_width()   - width of the per-word bit counters
//   ChainLen, WordW, NWords - default geometry (one connection block)
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StShift = 2'd2,
      StDone  = 2'd3
   } ccff_state_e;

   function automatic int unsigned nwords(input int unsigned chain_len,
                                          input int unsigned word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

   // Must be able to hold CHAIN_LEN itself, hence the +1.
   function automatic int unsigned rem_width(input int unsigned chain_len);
      return $clog2(chain_len + 1);
   endfunction

   // Must be able to hold WORD_W itself, hence the +1.
   function automatic int unsigned cnt_width(input int unsigned word_w);
      return $clog2(word_w + 1);
   endfunction

   localparam int unsigned ChainLen = 29;
   localparam int unsigned WordW    = 8;
   localparam int unsigned NWords   = nwords(ChainLen, WordW);

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bundle of the loader's handshake, chain and readback signals.
//   start             - one-cycle load request
//   bs_data/valid/ready - bitstream word handshake (bit 0 shifted first)
//   ccff_head/tail    - serial data into / out of the chain
//   shift_en          - chain clock enable
//   busy/done         - load status
//   rb_data/rb_valid  - packed readback word and its one-cycle strobe
// modport master: the host/chain side; modport slave: the loader.
interface ccff_chain_loader_if #(
   parameter int unsigned WORD_W = ccff_loader_pkg::WordW
) ();

   logic              start;
   logic [WORD_W-1:0] bs_data;
   logic              bs_valid;
   logic              bs_ready;
   logic              ccff_head;
   logic              ccff_tail;
   logic              shift_en;
   logic              busy;
   logic              done;
   logic [WORD_W-1:0] rb_data;
   logic              rb_valid;

   modport master (
      output start, bs_data, bs_valid, ccff_tail,
      input  bs_ready, ccff_head, shift_en, busy, done, rb_data, rb_valid
   );

   modport slave (
      input  start, bs_data, bs_valid, ccff_tail,
      output bs_ready, ccff_head, shift_en, busy, done, rb_data, rb_valid
   );

endinterface

// File: rtl/ccff_rb_packer.sv
// Serial-to-word packer for the chain readback.
// Ports:
//   prog_clk, prog_reset_n - clock, synchronous active-low reset
//   shift_en_i   - chain advances this cycle; ccff_tail_i holds the outgoing bit
//   last_i       - this cycle carries the final chain bit of the load
//   ccff_tail_i  - serial data from the chain tail
//   rb_data_o    - packed word, first tail bit in the LSB; held until next strobe
//   rb_valid_o   - one-cycle strobe when rb_data_o updates
module ccff_rb_packer
   import ccff_loader_pkg::*;
#(
   parameter int unsigned WORD_W = WordW
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              shift_en_i,
   input  logic              last_i,
   input  logic              ccff_tail_i,
   output logic [WORD_W-1:0] rb_data_o,
   output logic              rb_valid_o
);

   localparam int unsigned CW = cnt_width(WORD_W);
   localparam logic [CW-1:0] CntLast = CW'(WORD_W - 1);
   localparam logic [CW-1:0] CntOne  = CW'(1);

   logic [WORD_W-1:0] rb_shreg_q, rb_shreg_d;
   logic [WORD_W-1:0] rb_data_q, rb_data_d;
   logic [CW-1:0]     rbcnt_q, rbcnt_d;
   logic              rb_valid_q, rb_valid_d;
   logic [WORD_W-1:0] word;

   always_comb begin
      rb_shreg_d = rb_shreg_q;
      rb_data_d  = rb_data_q;
      rbcnt_d    = rbcnt_q;
      rb_valid_d = 1'b0;
      word       = rb_shreg_q | (WORD_W'(ccff_tail_i) << rbcnt_q);
      if (shift_en_i) begin
         if (rbcnt_q == CntLast || last_i) begin
            // Flush; the shift register is cleared so a short final word
            // comes out with its unused upper bits at zero.
            rb_data_d  = word;
            rb_valid_d = 1'b1;
            rb_shreg_d = '0;
            rbcnt_d    = '0;
         end else begin
            rb_shreg_d = word;
            rbcnt_d    = rbcnt_q + CntOne;
         end
      end
   end

   always_ff @(posedge prog_clk) begin
      if (!prog_reset_n) begin
         rb_shreg_q <= '0;
         rb_data_q  <= '0;
         rbcnt_q    <= '0;
         rb_valid_q <= 1'b0;
      end else begin
         rb_shreg_q <= rb_shreg_d;
         rb_data_q  <= rb_data_d;
         rbcnt_q    <= rbcnt_d;
         rb_valid_q <= rb_valid_d;
      end
   end

   assign rb_data_o  = rb_data_q;
   assign rb_valid_o = rb_valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Upstream driver for the ccff configuration chain. Accepts bitstream words
// over a valid/ready handshake, serialises them onto ccff_head one bit per
// cycle with shift_en high, and returns the displaced chain contents as
// packed readback words.
// Ports:
//   prog_clk      - configuration clock (only clock)
//   prog_reset_n  - synchronous active-low reset
//   bus (slave)   - start, bs_*, ccff_head/tail, shift_en, busy, done, rb_*
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = ChainLen,
   parameter int unsigned WORD_W    = WordW
) (
   input logic                prog_clk,
   input logic                prog_reset_n,
   ccff_chain_loader_if.slave bus
);

   localparam int unsigned RW = rem_width(CHAIN_LEN);
   localparam int unsigned CW = cnt_width(WORD_W);

   localparam logic [RW-1:0] RemInit = RW'(CHAIN_LEN);
   localparam logic [RW-1:0] RemOne  = RW'(1);
   localparam logic [CW-1:0] CntFull = CW'(WORD_W);
   localparam logic [CW-1:0] CntOne  = CW'(1);

   ccff_state_e       state_q, state_d;
   logic [RW-1:0]     remaining_q, remaining_d;
   logic [CW-1:0]     wbits_q, wbits_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic              bs_ready_q, bs_ready_d;
   logic              shift_en_q, shift_en_d;
   logic              head_q, head_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              last_bit;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      wbits_d     = wbits_q;
      shreg_d     = shreg_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d     = StFetch;
               remaining_d = RemInit;
            end
         end
         StFetch: begin
            if (bus.bs_valid && bs_ready_q) begin
               shreg_d = bus.bs_data;
               // Short final word: only the bits still needed are shifted.
               if (32'(remaining_q) < WORD_W) begin
                  wbits_d = CW'(remaining_q);
               end else begin
                  wbits_d = CntFull;
               end
               state_d = StShift;
            end
         end
         StShift: begin
            shreg_d     = shreg_q >> 1;
            remaining_d = remaining_q - RemOne;
            wbits_d     = wbits_q - CntOne;
            if (remaining_q == RemOne) begin
               state_d = StDone;
            end else if (wbits_q == CntOne) begin
               state_d = StFetch;
            end
         end
         StDone: begin
            if (bus.start) begin
               state_d     = StFetch;
               remaining_d = RemInit;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered copies decoded from the next state, so they
      // line up with the state they describe.
      bs_ready_d = (state_d == StFetch);
      shift_en_d = (state_d == StShift);
      head_d     = shreg_d[0];
      busy_d     = (state_d == StFetch) || (state_d == StShift);
      done_d     = (state_d == StDone);
   end

   always_ff @(posedge prog_clk) begin
      if (!prog_reset_n) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         wbits_q     <= '0;
         shreg_q     <= '0;
         bs_ready_q  <= 1'b0;
         shift_en_q  <= 1'b0;
         head_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         wbits_q     <= wbits_d;
         shreg_q     <= shreg_d;
         bs_ready_q  <= bs_ready_d;
         shift_en_q  <= shift_en_d;
         head_q      <= head_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign last_bit = shift_en_q && (remaining_q == RemOne);

   assign bus.bs_ready  = bs_ready_q;
   assign bus.shift_en  = shift_en_q;
   assign bus.ccff_head = head_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   ccff_rb_packer #(
      .WORD_W (WORD_W)
   ) u_rb_packer (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .shift_en_i   (shift_en_q),
      .last_i       (last_bit),
      .ccff_tail_i  (bus.ccff_tail),
      .rb_data_o    (bus.rb_data),
      .rb_valid_o   (bus.rb_valid)
   );

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;
   import ccff_loader_pkg::*;

   logic prog_clk;
   logic prog_reset_n;

   ccff_chain_loader_if #(.WORD_W(8)) bus ();

   ccff_chain_loader #(
      .CHAIN_LEN (29),
      .WORD_W    (8)
   ) dut (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .bus          (bus)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   // Behavioural 29-flop chain: head enters bit 0, tail is bit 28.
   logic [28:0] chain = '0;
   always @(posedge prog_clk) begin
      if (bus.shift_en) chain <= {chain[27:0], bus.ccff_head};
   end
   assign bus.ccff_tail = chain[28];

   int cyc = 0;
   always @(posedge prog_clk) cyc <= cyc + 1;

   // Monitors sample mid-cycle.
   int shift_cnt = 0;
   int hs_cnt    = 0;
   logic [7:0] rbq[$];
   always @(negedge prog_clk) begin
      if (bus.shift_en) shift_cnt++;
      if (bus.bs_valid && bus.bs_ready) hs_cnt++;
      if (bus.rb_valid) rbq.push_back(bus.rb_data);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge prog_clk);
      #1;
   endtask

   // Feeder state for the word currently being delivered.
   logic [31:0] cur_w;
   logic [31:0] cur_st;
   int wi;
   int left;

   // Called once per cycle: decides bs_valid/bs_data for the current cycle.
   task automatic feed();
      logic [31:0] t;
      if (bus.bs_ready && wi < 4) begin
         if (left > 0) begin
            bus.bs_valid = 1'b0;
            left--;
         end else begin
            t = cur_w >> (8 * wi);
            bus.bs_valid = 1'b1;
            bus.bs_data  = t[7:0];
            wi++;
            if (wi < 4) begin
               t = cur_st >> (8 * wi);
               left = int'(t[7:0]);
            end
         end
      end else begin
         // Not ready: junk on the bus must be ignored.
         bus.bs_valid = 1'($urandom_range(1));
         bus.bs_data  = 8'($urandom);
      end
   endtask

   // Full load. Expected chain = first 29 stream bits, bit-reversed so the
   // first bit sits at the tail. Expected readback = previous chain read
   // tail first, zero-padded to 32 bits.
   task automatic do_load(input logic [31:0] w, input logic [31:0] st, input int poke,
                          output int lat, output logic [31:0] rb_got);
      logic [28:0] snap;
      logic [28:0] old_stream;
      logic [28:0] new_stream;
      logic [28:0] exp_chain;
      logic [31:0] exp_rb;
      logic [31:0] t;
      int s0, h0, r0, t0, n;
      snap       = chain;
      old_stream = {<<{snap}};
      exp_rb     = 32'(old_stream);
      new_stream = w[28:0];
      exp_chain  = {<<{new_stream}};
      cur_w = w; cur_st = st; wi = 0;
      left  = int'(st[7:0]);
      s0 = shift_cnt; h0 = hs_cnt; r0 = rbq.size();
      bus.start = 1'b1;
      t0 = cyc;
      step();
      bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 400) begin
         feed();
         bus.start = (poke != 0 && n == poke);
         step();
         n++;
      end
      bus.start    = 1'b0;
      bus.bs_valid = 1'b0;
      lat = cyc - t0;
      check("done_reached", 32'(bus.done), 32'd1);
      step();  // lets the final readback strobe reach the monitor
      check("busy_after", 32'(bus.busy), 32'd0);
      check("done_held", 32'(bus.done), 32'd1);
      check("shift_count", 32'(shift_cnt - s0), 32'd29);
      check("handshakes", 32'(hs_cnt - h0), 32'(NWords));
      check("chain", 32'(chain), 32'(exp_chain));
      check("rb_count", 32'(rbq.size() - r0), 32'd4);
      rb_got = '0;
      for (int j = 0; j < 4; j++) begin
         t = exp_rb >> (8 * j);
         if (r0 + j < rbq.size()) begin
            check("rb_word", 32'(rbq[r0 + j]), 32'(t[7:0]));
            rb_got = rb_got | (32'(rbq[r0 + j]) << (8 * j));
         end
      end
      t = exp_rb >> 24;
      check("rb_data_hold", 32'(bus.rb_data), 32'(t[7:0]));
   endtask

   typedef struct packed {
      logic [31:0] words;   // word k in byte k
      logic [31:0] stalls;  // FETCH cycles with bs_valid low before word k
      logic [7:0]  poke;    // loop cycle for a start pulse while busy, 0 = none
      logic [7:0]  lat;     // cycles from start to done
      logic [31:0] rb;      // expected readback of the previous contents
   } vec_t;

   vec_t vecs [5];

   initial begin
      int lat, sum, s0, h0, g;
      logic [31:0] rb_got, w, st;

      vecs[0] = '{words: 32'h15FF3CA5, stalls: 32'h0,        poke: 8'd0,
                  lat: 8'd34, rb: 32'h00000000};
      vecs[1] = '{words: 32'h00000000, stalls: 32'h0,        poke: 8'd0,
                  lat: 8'd34, rb: 32'h15FF3CA5};
      vecs[2] = '{words: 32'h15FF3CA5, stalls: 32'h00000500, poke: 8'd0,
                  lat: 8'd39, rb: 32'h00000000};
      vecs[3] = '{words: 32'hFF332211, stalls: 32'h0,        poke: 8'd5,
                  lat: 8'd34, rb: 32'h15FF3CA5};
      vecs[4] = '{words: 32'h00000000, stalls: 32'h0,        poke: 8'd0,
                  lat: 8'd34, rb: 32'h1F332211};

      bus.start = 1'b0; bus.bs_valid = 1'b0; bus.bs_data = '0;
      prog_reset_n = 1'b0;
      step(); step();
      check("rst_bs_ready", 32'(bus.bs_ready), 32'd0);
      check("rst_shift_en", 32'(bus.shift_en), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_rb_valid", 32'(bus.rb_valid), 32'd0);
      check("rst_head", 32'(bus.ccff_head), 32'd0);
      check("rst_rb_data", 32'(bus.rb_data), 32'd0);
      prog_reset_n = 1'b1;

      // IDLE ignores bs_valid.
      h0 = hs_cnt; s0 = shift_cnt;
      bus.bs_valid = 1'b1; bus.bs_data = 8'hFF;
      step(); step(); step();
      bus.bs_valid = 1'b0;
      check("idle_ready", 32'(bus.bs_ready), 32'd0);
      check("idle_hs", 32'(hs_cnt - h0), 32'd0);
      check("idle_shift", 32'(shift_cnt - s0), 32'd0);

      for (int i = 0; i < 5; i++) begin
         do_load(vecs[i].words, vecs[i].stalls, int'(vecs[i].poke), lat, rb_got);
         check("vec_latency", 32'(lat), 32'(vecs[i].lat));
         check("vec_rb", rb_got, vecs[i].rb);
      end

      // Reset in the middle of a load.
      cur_w = 32'h0A0FC35A; cur_st = 32'h0; wi = 0; left = 0;
      s0 = shift_cnt; g = 0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      while (shift_cnt - s0 < 12 && g < 100) begin
         feed();
         step();
         g++;
      end
      check("abort_reached", 32'(shift_cnt - s0 >= 12), 32'd1);
      prog_reset_n = 1'b0;
      bus.bs_valid = 1'b0;
      step();
      check("abort_shift_en", 32'(bus.shift_en), 32'd0);
      check("abort_bs_ready", 32'(bus.bs_ready), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_rb_valid", 32'(bus.rb_valid), 32'd0);
      prog_reset_n = 1'b1;
      step();
      do_load(32'h0A0FC35A, 32'h0, 0, lat, rb_got);
      check("abort_reload_lat", 32'(lat), 32'd34);

      // Randomised loads against the reference model.
      for (int r = 0; r < 8; r++) begin
         w  = $urandom;
         st = {8'($urandom_range(3)), 8'($urandom_range(3)),
               8'($urandom_range(3)), 8'($urandom_range(3))};
         sum = int'(st[7:0]) + int'(st[15:8]) + int'(st[23:16]) + int'(st[31:24]);
         do_load(w, st, int'($urandom_range(1, 30)), lat, rb_got);
         check("rand_latency", 32'(lat), 32'(29 + NWords + 1 + sum));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Upstream driver for the configuration-chain (ccff) scan path: takes bitstream words over a valid/ready handshake and serialises them onto ccff_head, one bit per prog_clk.
- Asserts shift_en for every cycle in which the chain must advance. Top level uses shift_en as the enable of the clock gate on the chain's prog_clk.
- Captures ccff_tail bits while shifting and returns them packed as readback words, giving the previous chain contents for integrity checks.

Parameters:
- CHAIN_LEN, 29, total number of ccff flops on the chain (one connection block: 9 three-bit mem cells + 1 two-bit mem cell = 29).
- WORD_W, 8, bitstream and readback word width.
- NWORDS, ceil(CHAIN_LEN/WORD_W) = 4, derived; not to be overridden.

Ports:
- prog_clk  in  1  configuration clock; the only clock.
- prog_reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a load.
- bs_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- bs_valid  in  1  bs_data is valid.
- bs_ready  out  1  loader accepts a word this cycle.
- ccff_head  out  1  serial data into the chain head.
- ccff_tail  in  1  serial data out of the chain tail.
- shift_en  out  1  chain clock enable; the chain shifts on the prog_clk edge where this is 1.
- busy  out  1  a load is in progress.
- done  out  1  the last load completed; held high.
- rb_data  out  WORD_W  packed readback bits; LSB is the first tail bit.
- rb_valid  out  1  one-cycle strobe, rb_data is valid.

Behaviour:
- Clock and reset: one clock, prog_clk. Reset is synchronous and active-low on prog_reset_n.
- Reset values: state=IDLE; bs_ready, shift_en, busy, done, rb_valid = 0; ccff_head = 0; rb_data = 0; all counters = 0.
- Reset mid-load: the load aborts. shift_en is low from the first cycle after the reset edge. Chain contents are undefined. done stays 0.
- States:
  - IDLE: bs_ready=0, and bs_valid is ignored. On start go to FETCH, with remaining=CHAIN_LEN and busy=1.
  - FETCH: bs_ready=1 and shift_en=0, so the chain holds (bubble). On bs_valid&bs_ready: load shreg=bs_data, set wbits=min(WORD_W, remaining), go to SHIFT.
  - SHIFT: shift_en=1, ccff_head=shreg[0] (registered). Each cycle: shreg>>=1, remaining-=1, wbits-=1.
    - If remaining==1 this cycle, go to DONE.
    - Else if wbits==1, go to FETCH.
    - Upper bits of the final word beyond `remaining` are discarded.
  - DONE: busy=0, done=1, and done is held. start re-enters FETCH with remaining=CHAIN_LEN and clears done.
- start while busy: ignored.
- Stalls: bs_valid low in FETCH stalls indefinitely with shift_en=0. No timeout.
- Counts per load:
  - shift_en is high for exactly CHAIN_LEN cycles.
  - Exactly NWORDS handshakes occur.
  - Minimum latency from start to done is CHAIN_LEN+NWORDS+1 cycles (34 with defaults).
- Readback capture: on every cycle with shift_en=1, sample ccff_tail, the old chain bit present before that edge, into rb_shreg at position rbcnt, then rbcnt+=1.
  - rb_valid pulses for one cycle, registered, when rbcnt reaches WORD_W or the final chain bit is captured.
  - On the final word, unused upper bits of rb_data are 0.
  - rb_data holds its value until the next strobe.
  - There is no rb backpressure; the consumer must accept every strobe.
- Width rules: remaining is clog2(CHAIN_LEN+1) bits wide; wbits and rbcnt are clog2(WORD_W+1) bits wide. No wrap is possible within a load.

Decomposition:
- Package ccff_loader_pkg holds:
  - the state enum (IDLE, FETCH, SHIFT, DONE);
  - the clog2-based width localparams;
  - the NWORDS function.
- One sub-module, ccff_rb_packer: it does serial-to-word packing of ccff_tail, gated by shift_en and flushed on the last bit, and drives rb_data and rb_valid.

Test Plan:
- Test harness: a behavioural 29-flop chain clocked on prog_clk&shift_en.
- Basic load: start, then words 0xA5, 0x3C, 0xFF, 0x15 with no stalls -> shift_en high for exactly 29 cycles; chain holds the bits in order, last word contributing 5 bits (0x15 -> 10101); done high at cycle 34.
- Readback: repeat the load with 0x00 x4 -> rb_valid strobes 4 times; rb_data = 0xA5, 0x3C, 0xFF, 0x15.
- Stalls: drop bs_valid for 5 cycles before word 2 -> shift_en low throughout the stall; final chain contents identical to the basic load; done at cycle 39.
- Start while busy: pulse start mid-SHIFT -> ignored; handshake count stays 4; shift_en count stays 29.
- Reset mid-load: assert prog_reset_n=0 after 12 shifted bits -> next cycle shift_en=0, bs_ready=0, busy=0, done=0; a fresh start then completes a full 29-bit load correctly.
- Final-word masking: last word 0xFF -> only 5 ones shifted; readback final word has upper 3 bits 0.
